ice51_boot: RTL

Serial code loader for the ice51 system. It sits between the board UART receive pin and the code memory write port, in front of the CPU. After reset it receives a length-prefixed program image over 8N1 UART and writes it byte-by-byte into code memory from address 0. It then releases the CPU by asserting a run flag, or holds the CPU and flags an error if the header or checksum is bad.

---
 rtl/ice51_boot.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ice51_boot.sv
// Serial code loader: receives a length-prefixed image over 8N1 UART and writes it to code memory.
// Define ICE51_BOOT_CHECKSUM_EN to require and verify a trailing modulo-256 checksum byte.
module ice51_boot #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_code_wr,
    output logic [ADDR_W-1:0] o_code_addr,
    output logic [7:0]        o_code_data,
    output logic              o_cpu_run,
    output logic              o_busy,
    output logic              o_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      CAPACITY  = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        LOAD,
`ifdef ICE51_BOOT_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } ld_state_t;

`ifdef ICE51_BOOT_CHECKSUM_EN
    localparam ld_state_t AFTER_LOAD = CHK;
`else
    localparam ld_state_t AFTER_LOAD = DONE;
`endif

    // ---------------- UART receive front end ----------------
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             bit_tick;
    logic             start_ok, byte_stb, frame_err;

    assign rx_fall  = rx_prev & ~rx_s2;
    assign bit_tick = (rx_cnt == BIT_LAST);

    always_comb begin
        rx_next   = rx_state;
        start_ok  = 1'b0;
        byte_stb  = 1'b0;
        frame_err = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) begin
                // A start bit that is high again at mid-bit was a glitch.
                if (!rx_s2) begin
                    rx_next  = RX_DATA;
                    start_ok = 1'b1;
                end else begin
                    rx_next = RX_IDLE;
                end
            end
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) begin
                rx_next = RX_IDLE;
                if (rx_s2) byte_stb  = 1'b1;
                else       frame_err = 1'b1;
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= i_uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_next != rx_state || bit_tick) rx_cnt <= '0;
            else                                 rx_cnt <= rx_cnt + 1'b1;
            if (start_ok) bit_idx <= '0;
            if (rx_state == RX_DATA && bit_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    // ---------------- Loader ----------------
    ld_state_t         state, state_next;
    logic [7:0]        len_lo;
    logic [15:0]       length;
    logic [ADDR_W:0]   count, cnt_inc;
    logic [16:0]       hdr_len;
    logic              terminal;
`ifdef ICE51_BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign cnt_inc  = count + 1'b1;
    assign hdr_len  = {1'b0, rx_shift, len_lo};
    assign terminal = (state == DONE) || (state == ERROR);

    always_comb begin
        state_next = state;
        unique case (state)
            HDR_LO: if (byte_stb) state_next = HDR_HI;
            HDR_HI: if (byte_stb) begin
                if (hdr_len > CAPACITY) state_next = ERROR;
                else if (hdr_len == '0) state_next = AFTER_LOAD;
                else                    state_next = LOAD;
            end
            LOAD:   if (byte_stb && 17'(cnt_inc) == {1'b0, length}) state_next = AFTER_LOAD;
`ifdef ICE51_BOOT_CHECKSUM_EN
            CHK:    if (byte_stb) state_next = (rx_shift == csum) ? DONE : ERROR;
`endif
            DONE:   state_next = DONE;
            ERROR:  state_next = ERROR;
            default: state_next = ERROR;
        endcase
        if (frame_err && !terminal) state_next = ERROR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= HDR_LO;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_lo      <= '0;
            length      <= '0;
            count       <= '0;
            o_code_wr   <= 1'b0;
            o_code_addr <= '0;
            o_code_data <= '0;
            o_cpu_run   <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
`ifdef ICE51_BOOT_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            o_code_wr <= 1'b0;
            if (state == HDR_LO && byte_stb) len_lo <= rx_shift;
            if (state == HDR_HI && byte_stb) length <= {rx_shift, len_lo};
            if (state == LOAD && byte_stb) begin
                o_code_wr   <= 1'b1;
                o_code_addr <= count[ADDR_W-1:0];
                o_code_data <= rx_shift;
                count       <= cnt_inc;
`ifdef ICE51_BOOT_CHECKSUM_EN
                csum        <= csum + rx_shift;
`endif
            end
            o_cpu_run <= o_cpu_run | (state_next == DONE);
            o_err     <= o_err | (state_next == ERROR);
            if (state_next == DONE || state_next == ERROR) o_busy <= 1'b0;
            else if (start_ok)                             o_busy <= 1'b1;
        end
    end

endmodule
